// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the data-cache controller: bus/size encodings, MSHR entry
// layout and the load-data extraction helper.
package dcache_ctrl_pkg;

    localparam int unsigned DCACHE_IDX_WIDTH = 4;
    localparam int unsigned DCACHE_TAG_WIDTH = 32 - 3 - DCACHE_IDX_WIDTH;
    localparam int unsigned LQ_ID_MAX_WIDTH  = 8;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        MSHR_INVALID    = 2'h0,
        MSHR_WAIT_ISSUE = 2'h1,
        MSHR_WAIT_DATA  = 2'h2
    } MSHR_STATE;

    typedef struct packed {
        MSHR_STATE                   state;
        logic [DCACHE_TAG_WIDTH-1:0] tag;
        logic [DCACHE_IDX_WIDTH-1:0] idx;
        logic [2:0]                  offset;
        logic [2:0]                  size;
        logic [LQ_ID_MAX_WIDTH-1:0]  ld_id;
        logic [3:0]                  mem_tag;
    } MSHR_ENTRY;

    // size[2] set means zero-extend; DOUBLE returns the low word of the shifted block
    function automatic logic [31:0] load_extract(input logic [63:0] blk,
                                                 input logic [2:0]  offset,
                                                 input logic [2:0]  size);
        logic [63:0] sh;
        logic [31:0] res;
        sh = blk >> {offset, 3'b000};
        case (size[1:0])
            BYTE:    res = size[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            HALF:    res = size[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = sh[31:0];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dcache_ctrl_mshr.sv
// MSHR table: entry array, lowest-free / lowest-issue priority encoders,
// fill tag match and same-block conflict detection.
module dcache_mshr
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned MSHR_NUM = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        alloc_en,
    input  MSHR_ENTRY                   alloc_entry,
    input  logic                        issue_ack,
    input  logic [3:0]                  issue_mem_tag,
    input  logic [3:0]                  fill_tag,
    input  logic [DCACHE_TAG_WIDTH-1:0] ld_tag,
    input  logic [DCACHE_IDX_WIDTH-1:0] ld_idx,
    input  logic [DCACHE_TAG_WIDTH-1:0] st_tag,
    input  logic [DCACHE_IDX_WIDTH-1:0] st_idx,
    output logic                        free_valid,
    output logic                        issue_valid,
    output MSHR_ENTRY                   issue_entry,
    output logic                        fill_hit,
    output MSHR_ENTRY                   fill_entry,
    output logic                        ld_conflict,
    output logic                        st_conflict
);

    localparam int unsigned SEL_W = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;

    MSHR_ENTRY        mshr [MSHR_NUM];
    logic [SEL_W-1:0] free_sel;
    logic [SEL_W-1:0] issue_sel;
    logic [SEL_W-1:0] fill_sel;

    always_comb begin
        free_valid  = 1'b0;
        issue_valid = 1'b0;
        fill_hit    = 1'b0;
        ld_conflict = 1'b0;
        st_conflict = 1'b0;
        free_sel    = '0;
        issue_sel   = '0;
        fill_sel    = '0;
        for (int unsigned i = 0; i < MSHR_NUM; i++) begin
            if (!free_valid && mshr[i].state == MSHR_INVALID) begin
                free_valid = 1'b1;
                free_sel   = SEL_W'(i);
            end
            if (!issue_valid && mshr[i].state == MSHR_WAIT_ISSUE) begin
                issue_valid = 1'b1;
                issue_sel   = SEL_W'(i);
            end
            if (!fill_hit && fill_tag != 4'd0 && mshr[i].state == MSHR_WAIT_DATA &&
                mshr[i].mem_tag == fill_tag) begin
                fill_hit = 1'b1;
                fill_sel = SEL_W'(i);
            end
            if (mshr[i].state != MSHR_INVALID) begin
                if (mshr[i].tag == ld_tag && mshr[i].idx == ld_idx) ld_conflict = 1'b1;
                if (mshr[i].tag == st_tag && mshr[i].idx == st_idx) st_conflict = 1'b1;
            end
        end
        issue_entry = mshr[issue_sel];
        fill_entry  = mshr[fill_sel];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < MSHR_NUM; i++) mshr[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < MSHR_NUM; i++) begin
                if (fill_hit && fill_sel == SEL_W'(i))
                    mshr[i].state <= MSHR_INVALID;
                if (issue_ack && issue_valid && issue_sel == SEL_W'(i)) begin
                    mshr[i].state   <= MSHR_WAIT_DATA;
                    mshr[i].mem_tag <= issue_mem_tag;
                end
                if (alloc_en && free_valid && free_sel == SEL_W'(i))
                    mshr[i] <= alloc_entry;
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-through, no-write-allocate data-cache controller with non-blocking loads.
// Optional hit/miss/stall counters are built when DCACHE_CTRL_STATS_EN is defined.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned MSHR_NUM     = 4,
    parameter int unsigned LQ_IDX_WIDTH = 3
) (
    input  logic                        clock,
    input  logic                        reset,
`ifdef DCACHE_CTRL_STATS_EN
    output logic [31:0]                 hit_cnt,
    output logic [31:0]                 miss_cnt,
    output logic [31:0]                 stall_cnt,
`endif
    input  logic                        ld_req_valid,
    input  logic [31:0]                 ld_req_addr,
    input  logic [2:0]                  ld_req_size,
    input  logic [LQ_IDX_WIDTH-1:0]     ld_req_id,
    output logic                        ld_req_ready,
    output logic                        ld_resp_valid,
    output logic [LQ_IDX_WIDTH-1:0]     ld_resp_id,
    output logic [31:0]                 ld_resp_data,
    input  logic                        st_req_valid,
    input  logic [31:0]                 st_req_addr,
    input  logic [2:0]                  st_req_size,
    input  logic [31:0]                 st_req_data,
    output logic                        st_req_ready,
    output logic                        rd_en,
    output logic [DCACHE_IDX_WIDTH-1:0] rd_idx,
    output logic [DCACHE_TAG_WIDTH-1:0] rd_tag,
    output logic                        wr_en_mem,
    output logic                        wr_en_lsq,
    output logic [DCACHE_IDX_WIDTH-1:0] wr_idx,
    output logic [DCACHE_TAG_WIDTH-1:0] wr_tag,
    output logic [63:0]                 wr_data,
    output logic [2:0]                  cache_size,
    output logic                        cache_offset,
    input  logic                        dcache_rd_valid,
    input  logic                        dcache_wr_valid,
    input  logic [63:0]                 rd_data,
    output BUS_COMMAND                  proc2Dmem_command,
    output logic [31:0]                 proc2Dmem_addr,
    output logic [2:0]                  proc2Dmem_size,
    output logic [63:0]                 proc2Dmem_data,
    input  logic [3:0]                  Dmem2proc_response,
    input  logic [3:0]                  Dmem2proc_tag,
    input  logic [63:0]                 Dmem2proc_data
);

    logic [DCACHE_TAG_WIDTH-1:0] ld_tag;
    logic [DCACHE_IDX_WIDTH-1:0] ld_idx;
    logic [DCACHE_TAG_WIDTH-1:0] st_tag;
    logic [DCACHE_IDX_WIDTH-1:0] st_idx;

    logic      free_valid;
    logic      issue_valid;
    logic      fill_hit;
    logic      ld_conflict;
    logic      st_conflict;
    MSHR_ENTRY issue_entry;
    MSHR_ENTRY fill_entry;
    MSHR_ENTRY alloc_entry;
    logic      alloc_en;
    logic      issue_ack;
    logic      store_accept;
    logic      load_hit;

    assign ld_tag = ld_req_addr[31:3+DCACHE_IDX_WIDTH];
    assign ld_idx = ld_req_addr[3 +: DCACHE_IDX_WIDTH];
    assign st_tag = st_req_addr[31:3+DCACHE_IDX_WIDTH];
    assign st_idx = st_req_addr[3 +: DCACHE_IDX_WIDTH];

    assign alloc_entry = '{state:   MSHR_WAIT_ISSUE,
                           tag:     ld_tag,
                           idx:     ld_idx,
                           offset:  ld_req_addr[2:0],
                           size:    ld_req_size,
                           ld_id:   LQ_ID_MAX_WIDTH'(ld_req_id),
                           mem_tag: 4'd0};

    dcache_mshr #(
        .MSHR_NUM(MSHR_NUM)
    ) u_mshr (
        .clock        (clock),
        .reset        (reset),
        .alloc_en     (alloc_en),
        .alloc_entry  (alloc_entry),
        .issue_ack    (issue_ack),
        .issue_mem_tag(Dmem2proc_response),
        .fill_tag     (Dmem2proc_tag),
        .ld_tag       (ld_tag),
        .ld_idx       (ld_idx),
        .st_tag       (st_tag),
        .st_idx       (st_idx),
        .free_valid   (free_valid),
        .issue_valid  (issue_valid),
        .issue_entry  (issue_entry),
        .fill_hit     (fill_hit),
        .fill_entry   (fill_entry),
        .ld_conflict  (ld_conflict),
        .st_conflict  (st_conflict)
    );

    always_comb begin
        ld_req_ready      = 1'b0;
        ld_resp_valid     = 1'b0;
        ld_resp_id        = '0;
        ld_resp_data      = '0;
        st_req_ready      = 1'b0;
        rd_en             = 1'b0;
        rd_idx            = '0;
        rd_tag            = '0;
        wr_en_mem         = 1'b0;
        wr_en_lsq         = 1'b0;
        wr_idx            = '0;
        wr_tag            = '0;
        wr_data           = '0;
        cache_size        = '0;
        cache_offset      = 1'b0;
        proc2Dmem_command = BUS_NONE;
        proc2Dmem_addr    = '0;
        proc2Dmem_size    = '0;
        proc2Dmem_data    = '0;
        alloc_en          = 1'b0;
        issue_ack         = 1'b0;
        store_accept      = 1'b0;
        load_hit          = 1'b0;
        if (!reset) begin
            // a store is only presented to memory when it can also take the cache port,
            // so memory never sees a store the LSQ will replay
            if (issue_valid) begin
                proc2Dmem_command = BUS_LOAD;
                proc2Dmem_addr    = {issue_entry.tag, issue_entry.idx, 3'b000};
                proc2Dmem_size    = {1'b0, DOUBLE};
                issue_ack         = (Dmem2proc_response != 4'd0);
            end else if (st_req_valid && !fill_hit && !st_conflict) begin
                proc2Dmem_command = BUS_STORE;
                proc2Dmem_addr    = st_req_addr;
                proc2Dmem_size    = st_req_size;
                proc2Dmem_data    = {32'b0, st_req_data};
                store_accept      = (Dmem2proc_response != 4'd0);
            end

            if (fill_hit) begin
                wr_en_mem     = 1'b1;
                wr_idx        = fill_entry.idx;
                wr_tag        = fill_entry.tag;
                wr_data       = Dmem2proc_data;
                cache_size    = {1'b0, DOUBLE};
                ld_resp_valid = 1'b1;
                ld_resp_id    = fill_entry.ld_id[LQ_IDX_WIDTH-1:0];
                ld_resp_data  = load_extract(Dmem2proc_data, fill_entry.offset, fill_entry.size);
            end else if (store_accept) begin
                st_req_ready = 1'b1;
                wr_en_lsq    = 1'b1;
                wr_idx       = st_idx;
                wr_tag       = st_tag;
                wr_data      = {32'b0, st_req_data};
                cache_size   = st_req_size;
                cache_offset = st_req_addr[2];
            end else if (ld_req_valid) begin
                rd_en        = 1'b1;
                rd_idx       = ld_idx;
                rd_tag       = ld_tag;
                cache_size   = ld_req_size;
                cache_offset = ld_req_addr[2];
                if (!ld_conflict) begin
                    if (dcache_rd_valid) begin
                        load_hit      = 1'b1;
                        ld_req_ready  = 1'b1;
                        ld_resp_valid = 1'b1;
                        ld_resp_id    = ld_req_id;
                        ld_resp_data  = load_extract(rd_data, ld_req_addr[2:0], ld_req_size);
                    end else if (free_valid) begin
                        ld_req_ready = 1'b1;
                        alloc_en     = 1'b1;
                    end
                end
            end
        end
    end

`ifdef DCACHE_CTRL_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (load_hit)                     hit_cnt   <= hit_cnt + 32'd1;
            if (alloc_en)                     miss_cnt  <= miss_cnt + 32'd1;
            if (ld_req_valid && !ld_req_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Data-cache controller sitting directly upstream of dcache_mem, between the LSQ and the cache array/memory bus.
- Accepts one LSQ load or store per cycle and performs the cache lookup.
- Tracks outstanding load misses in a small MSHR table, issues BUS_LOAD/BUS_STORE on the data-memory port, and writes returning blocks into dcache_mem.
- Write-through, no-write-allocate; loads are non-blocking up to MSHR_NUM misses.

Parameters:
- MSHR_NUM, 4: outstanding load-miss entries.
- LQ_IDX_WIDTH, 3: width of the LSQ load id returned with load data.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ld_req_valid  in  1  LSQ load request
- ld_req_addr  in  32  byte address
- ld_req_size  in  3  [1:0] MEM_SIZE; [2]=1 unsigned
- ld_req_id  in  LQ_IDX_WIDTH  LSQ load id
- ld_req_ready  out  1  load accepted this cycle
- ld_resp_valid  out  1  load data valid
- ld_resp_id  out  LQ_IDX_WIDTH  id of completing load
- ld_resp_data  out  32  extended load data
- st_req_valid  in  1  LSQ store request
- st_req_addr  in  32  byte address
- st_req_size  in  3  store size
- st_req_data  in  32  store data
- st_req_ready  out  1  store accepted (cache updated if hit, memory accepted)
- rd_en, rd_idx, rd_tag  out  1/`DCACHE_IDX_WIDTH/`DCACHE_TAG_WIDTH  cache read
- wr_en_mem, wr_en_lsq, wr_idx, wr_tag  out  1/1/`DCACHE_IDX_WIDTH/`DCACHE_TAG_WIDTH  cache write
- wr_data  out  64  fill block or store data
- cache_size  out  3  size to cache (drives dcache_mem proc2Dmem_size)
- cache_offset  out  1  address bit 2
- dcache_rd_valid, dcache_wr_valid  in  1  read hit / store hit
- rd_data  in  64  cache block
- proc2Dmem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE
- proc2Dmem_addr  out  32  block-aligned for loads, byte address for stores
- proc2Dmem_size  out  3  DOUBLE for loads, store size for stores
- proc2Dmem_data  out  64  {32'b0, st_req_data}
- Dmem2proc_response  in  4  0 = rejected, else transaction tag
- Dmem2proc_tag  in  4  completing transaction tag, 0 = none
- Dmem2proc_data  in  64  returning block

Behaviour:
- Address split: offset = addr[2:0]; idx = addr[3 +: `DCACHE_IDX_WIDTH]; tag = the bits above.
- Reset: all MSHRs INVALID. All outputs 0, with proc2Dmem_command = BUS_NONE.
- MSHR entry states: INVALID → WAIT_ISSUE (on miss allocation) → WAIT_DATA (memory accepted; mem_tag recorded) → INVALID (on fill).
- Cache port priority within a cycle: fill > store > load. At most one cache operation per cycle.
- Fill:
  - Triggered when Dmem2proc_tag != 0 and matches a WAIT_DATA entry's mem_tag.
  - Drive wr_en_mem=1 with the entry's idx/tag and wr_data=Dmem2proc_data.
  - Assert ld_resp_valid with the entry's id and data extracted from Dmem2proc_data.
  - Free the entry.
  - A non-matching tag is ignored.
- Memory port arbitration, one command per cycle:
  - The lowest-index WAIT_ISSUE entry has priority over a store.
  - If Dmem2proc_response == 0, the command is retried next cycle.
- Load, when no fill this cycle:
  - Drive rd_en.
  - On dcache_rd_valid: ld_req_ready=1 and ld_resp_valid=1 in the same cycle (0-cycle hit latency).
  - On miss: accept only if a free MSHR exists and no valid MSHR has the same {tag,idx}. Allocate the lowest free entry. Otherwise ld_req_ready=0.
- Store, when no fill this cycle, no valid MSHR to the same block, and the store wins the memory port with a nonzero response:
  - st_req_ready=1.
  - Drive wr_en_lsq=1 (dcache_mem ignores a miss).
  - If a store is accepted, no load is accepted that cycle.
- Load extraction: shift the block right by offset*8; select byte/half/word; sign-extend unless size[2]=1.
- A store and a load to a block with an outstanding miss both stall until the fill completes.
- Reset mid-miss: entries are dropped; late memory tags are ignored.

Optional Feature:
- Macro: DCACHE_CTRL_STATS_EN.
- Defined: adds 32-bit output ports hit_cnt, miss_cnt, stall_cnt, all zeroed on reset.
  - hit_cnt increments on a load hit.
  - miss_cnt increments on MSHR allocation.
  - stall_cnt increments on a cycle with ld_req_valid & !ld_req_ready.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package / sys_defs additions:
  - MSHR_STATE enum {MSHR_INVALID, MSHR_WAIT_ISSUE, MSHR_WAIT_DATA}.
  - MSHR_ENTRY struct {state, tag, idx, offset, size, ld_id, mem_tag}.
- Reused: MEM_SIZE, BUS_COMMAND.
- Sub-module dcache_mshr:
  - Holds the entry array and free/issue priority encoders.
  - Performs tag-match for fill and the same-block check.
  - Controller holds the arbitration and extraction logic.

Test Plan:
- Preload block 0x100 via fill; load word 0x104 signed, value 0x8000_0000 → same-cycle ld_resp_valid, data 0x8000_0000, ld_req_ready=1.
- Load 0x200 miss, response=3 next cycle, Dmem2proc_tag=3 five cycles later → wr_en_mem=1, wr_idx for 0x200, ld_resp_id matches; following load to 0x200 hits.
- Five misses to distinct blocks with memory tags withheld → 4 accepted, 5th ld_req_ready=0 until the first fill.
- Dmem2proc_response=0 for 3 cycles on a miss issue → command repeats each cycle with the same address; entry stays WAIT_ISSUE, then WAIT_DATA on a nonzero response.
- Store byte 0xAB to cached 0x101 → wr_en_lsq=1, BUS_STORE addr 0x101; subsequent unsigned byte load returns 0x0000_00AB.
- Miss outstanding with mem_tag 5, reset asserted, then Dmem2proc_tag=5 → no wr_en_mem, no ld_resp_valid.
